// File: rtl/io_port_hub.sv
// io_port_hub: 8080 I/O bus glue between the CPU core and its peripherals.
// Latches the status word and port address on SYNC, decodes device channels,
// muxes read data back to the CPU and posts writes through a small FIFO that
// drains one single-cycle strobe per entry once the target channel is ready.
// Optional feature macro: IOBUS_FULL_WAIT_EN (stall the CPU while the FIFO is full
// instead of dropping the write and raising the sticky overflow flag).
module io_port_hub #(
    parameter int NCH        = 8,
    parameter int DEV_BITS   = 3,
    parameter int ADDR_LSB   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk24,
    input  logic                            mreset_n,
    input  logic                            cpu_ce,
    input  logic                            sync,
    input  logic                            wr_n,
    input  logic [15:0]                     cpu_a,
    input  logic [7:0]                      cpu_do,
    output logic [7:0]                      status_word,
    output logic                            io_read,
    output logic                            io_write,
    output logic                            int_ack,
    output logic                            cpu_ready,
    output logic [7:0]                      io_rdata,
    input  logic [NCH*8-1:0]                ch_rdata,
    output logic [NCH-1:0]                  ch_rsel,
    output logic [7:0]                      ch_wdata,
    output logic [ADDR_LSB-1:0]             ch_wsub,
    output logic [NCH-1:0]                  ch_wstb,
    input  logic [NCH-1:0]                  ch_wready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int LW        = AW + 1;
    localparam int EW        = DEV_BITS + ADDR_LSB + 8;
    localparam int FIELD_TOP = ADDR_LSB + DEV_BITS;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [7:0]           pa;
    logic                 wr_taken;
    logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;

    logic [DEV_BITS-1:0]  dev;
    logic [ADDR_LSB-1:0]  sub;
    logic [7:0]           pa_upper;
    logic                 hit;
    logic                 rd_sel;

    logic [EW-1:0]        head;
    logic [DEV_BITS-1:0]  head_dev;
    logic [ADDR_LSB-1:0]  head_sub;
    logic [7:0]           head_data;
    logic                 head_ready;
    logic [NCH-1:0]       head_onehot;

    logic                 full;
    logic                 empty;
    logic                 wr_pending;
    logic                 wr_req;
    logic                 push;
    logic                 pop;

    logic                 unused_addr_hi;

    // The upper address byte is not part of the 8080 port address.
    assign unused_addr_hi = ^cpu_a[15:8];

    assign io_read    = status_word[6];
    assign io_write   = status_word[4];
    assign int_ack    = status_word[0];
    assign fifo_level = level;

    // Port address decode: device field, sub-address and "above the device field is zero".
    assign dev      = pa[FIELD_TOP-1:ADDR_LSB];
    assign sub      = pa[ADDR_LSB-1:0];
    assign pa_upper = pa >> FIELD_TOP;
    assign hit      = (pa_upper == 8'h00) && (int'(dev) < NCH);
    assign rd_sel   = io_read & hit;

    // FIFO head fields, packed as {dev, sub, data}.
    assign head      = fifo_mem[rd_ptr];
    assign head_dev  = head[EW-1 -: DEV_BITS];
    assign head_sub  = head[8 +: ADDR_LSB];
    assign head_data = head[7:0];

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // A write is pending until the first push of this bus cycle sets wr_taken.
    assign wr_pending = io_write & hit & ~wr_n & ~wr_taken;
    assign wr_req     = cpu_ce & wr_pending;
    assign push       = wr_req & ~full;
    assign pop        = ~empty & head_ready;

    // Read mux and one-hot read select for the addressed channel.
    always_comb begin
        ch_rsel  = '0;
        io_rdata = 8'hFF;
        for (int k = 0; k < NCH; k++) begin
            if (rd_sel && (int'(dev) == k)) begin
                ch_rsel[k] = 1'b1;
                io_rdata   = ch_rdata[8*k +: 8];
            end
        end
    end

    // Ready lookup and strobe pattern for the channel addressed by the FIFO head.
    always_comb begin
        head_ready  = 1'b0;
        head_onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(head_dev) == k) begin
                head_ready     = ch_wready[k];
                head_onehot[k] = 1'b1;
            end
        end
    end

    // Latch status word and port address on SYNC; wr_taken limits each bus cycle to one push.
    always_ff @(posedge clk24) begin
        if (!mreset_n) begin
            status_word <= 8'h00;
            pa          <= 8'h00;
            wr_taken    <= 1'b0;
        end else if (cpu_ce && sync) begin
            status_word <= cpu_do;
            pa          <= cpu_a[7:0];
            wr_taken    <= 1'b0;
        end else if (push) begin
            wr_taken    <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk24) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dev, sub, cpu_do};
        end
    end

    // FIFO pointers and occupancy; a same-edge push and pop leave the level unchanged.
    always_ff @(posedge clk24) begin
        if (!mreset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered drain outputs: one strobe cycle per popped entry, data valid alongside it.
    always_ff @(posedge clk24) begin
        if (!mreset_n) begin
            ch_wstb  <= '0;
            ch_wdata <= 8'h00;
            ch_wsub  <= '0;
        end else if (pop) begin
            ch_wstb  <= head_onehot;
            ch_wdata <= head_data;
            ch_wsub  <= head_sub;
        end else begin
            ch_wstb  <= '0;
        end
    end

`ifdef IOBUS_FULL_WAIT_EN
    // Hold the CPU in its write cycle until the FIFO has room; nothing is ever dropped.
    assign cpu_ready = ~(full & wr_pending);
    assign overflow  = 1'b0;
`else
    assign cpu_ready = 1'b1;

    // Sticky flag recording that a write arrived while the FIFO was full and was lost.
    always_ff @(posedge clk24) begin
        if (!mreset_n) begin
            overflow <= 1'b0;
        end else if (wr_req && full) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_io_port_hub.sv
// Testbench for io_port_hub: drives 8080-style bus cycles and checks decode,
// read muxing and the posted-write FIFO against a scoreboard of expected strobes.
// Honours IOBUS_FULL_WAIT_EN for the full-FIFO scenario.
module tb_io_port_hub;

    logic        clk24 = 1'b0;
    logic        mreset_n;
    logic        cpu_ce;
    logic        sync;
    logic        wr_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  status_word;
    logic        io_read;
    logic        io_write;
    logic        int_ack;
    logic        cpu_ready;
    logic [7:0]  io_rdata;
    logic [63:0] ch_rdata;
    logic [7:0]  ch_rsel;
    logic [7:0]  ch_wdata;
    logic [1:0]  ch_wsub;
    logic [7:0]  ch_wstb;
    logic [7:0]  ch_wready;
    logic [2:0]  fifo_level;
    logic        overflow;

    typedef struct {
        logic [2:0] dev;
        logic [1:0] sub;
        logic [7:0] data;
        int         pushCyc;
        bit         latChk;
    } expWrite_t;

    expWrite_t sbQueue[$];
    int errorCount = 0;
    int checkCount = 0;
    int cyc = 0;

    io_port_hub dut (
        .clk24       (clk24),
        .mreset_n    (mreset_n),
        .cpu_ce      (cpu_ce),
        .sync        (sync),
        .wr_n        (wr_n),
        .cpu_a       (cpu_a),
        .cpu_do      (cpu_do),
        .status_word (status_word),
        .io_read     (io_read),
        .io_write    (io_write),
        .int_ack     (int_ack),
        .cpu_ready   (cpu_ready),
        .io_rdata    (io_rdata),
        .ch_rdata    (ch_rdata),
        .ch_rsel     (ch_rsel),
        .ch_wdata    (ch_wdata),
        .ch_wsub     (ch_wsub),
        .ch_wstb     (ch_wstb),
        .ch_wready   (ch_wready),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    // Free-running system clock.
    always #5 clk24 = ~clk24;

    // Count rising edges so strobe latency can be measured.
    always @(posedge clk24) cyc <= cyc + 1;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Address/status cycle: SYNC with the status word on the data bus.
    task automatic applyStimulus(input logic [7:0] status, input logic [7:0] port);
        @(negedge clk24);
        cpu_a  = {8'h00, port};
        cpu_do = status;
        sync   = 1'b1;
        cpu_ce = 1'b1;
        @(negedge clk24);
        sync   = 1'b0;
        cpu_ce = 1'b0;
    endtask

    // OUT cycle with WR_n held low for a number of cpu_ce ticks.
    task automatic busWrite(input logic [7:0] port, input logic [7:0] data, input int ticks,
                            input bit accepted, input bit latChk);
        expWrite_t e;
        applyStimulus(8'h10, port);
        cpu_do = data;
        for (int i = 0; i < ticks; i++) begin
            wr_n   = 1'b0;
            cpu_ce = 1'b1;
            if (i == 0 && accepted) begin
                e.dev     = port[4:2];
                e.sub     = port[1:0];
                e.data    = data;
                e.pushCyc = cyc + 1;
                e.latChk  = latChk;
                sbQueue.push_back(e);
            end
            @(negedge clk24);
            cpu_ce = 1'b0;
            @(negedge clk24);
        end
        wr_n = 1'b1;
    endtask

    // Wait (bounded) until every expected strobe has been observed.
    task automatic waitDrain(input string tag);
        int n = 0;
        while (sbQueue.size() != 0 && n < 40) begin
            @(negedge clk24);
            n++;
        end
        checkOutput(tag, sbQueue.size(), 0);
    endtask

    // Scoreboard side: every strobe must match the oldest outstanding write.
    always @(negedge clk24) begin
        expWrite_t e;
        if (ch_wstb !== 8'h00) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_wstb", ch_wstb, 8'h00);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("wstb", ch_wstb, 8'(8'h01 << e.dev));
                checkOutput("wdata", ch_wdata, e.data);
                checkOutput("wsub", ch_wsub, e.sub);
                if (e.latChk) begin
                    checkOutput("latency", 32'(cyc - e.pushCyc), 1);
                end
            end
        end
    end

    initial begin
        mreset_n  = 1'b0;
        cpu_ce    = 1'b1;
        sync      = 1'b1;
        wr_n      = 1'b1;
        cpu_a     = 16'h1234;
        cpu_do    = 8'hFF;
        ch_wready = 8'hFF;
        for (int k = 0; k < 8; k++) ch_rdata[8*k +: 8] = 8'h10 + 8'(k);
        ch_rdata[7:0]   = 8'hA5;
        ch_rdata[63:56] = 8'h5A;

        // Reset held for two edges while the bus keeps toggling.
        @(negedge clk24);
        cpu_ce = 1'b0;
        @(negedge clk24);
        checkOutput("rst_status", status_word, 8'h00);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_wstb", ch_wstb, 8'h00);
        checkOutput("rst_wdata", ch_wdata, 8'h00);
        checkOutput("rst_wsub", ch_wsub, 0);
        checkOutput("rst_ready", cpu_ready, 1);
        checkOutput("rst_rdata", io_rdata, 8'hFF);
        checkOutput("rst_ovf", overflow, 0);
        mreset_n = 1'b1;
        sync     = 1'b0;
        cpu_ce   = 1'b0;

        // Read decode and mux.
        applyStimulus(8'h40, 8'h01);
        checkOutput("rd0_status", status_word, 8'h40);
        checkOutput("rd0_ioread", io_read, 1);
        checkOutput("rd0_rsel", ch_rsel, 8'h01);
        checkOutput("rd0_rdata", io_rdata, 8'hA5);
        applyStimulus(8'h40, 8'h41);
        checkOutput("rd_miss_rsel", ch_rsel, 8'h00);
        checkOutput("rd_miss_rdata", io_rdata, 8'hFF);
        applyStimulus(8'h41, 8'h1D);
        checkOutput("rd7_rsel", ch_rsel, 8'h80);
        checkOutput("rd7_rdata", io_rdata, 8'h5A);
        checkOutput("rd7_intack", int_ack, 1);
        applyStimulus(8'h40, 8'h09);
        checkOutput("rd2_rsel", ch_rsel, 8'h04);
        checkOutput("rd2_rdata", io_rdata, 8'h12);
        applyStimulus(8'h00, 8'h01);
        checkOutput("rd_none_rsel", ch_rsel, 8'h00);
        checkOutput("rd_none_rdata", io_rdata, 8'hFF);

        // Single write held for three ticks: one push, one strobe two edges later.
        busWrite(8'h0C, 8'h3F, 3, 1, 1);
        checkOutput("wr1_iowrite", io_write, 1);
        waitDrain("wr1_drain");
        checkOutput("wr1_level", fifo_level, 0);

        // Write to an undecoded port is ignored.
        busWrite(8'h40, 8'h77, 1, 0, 0);
        checkOutput("miss_level", fifo_level, 0);

        // Fill the FIFO behind a stalled channel 3.
        ch_wready = 8'hF7;
        for (int i = 0; i < 4; i++) busWrite(8'h0C, 8'h10 + 8'(i), 1, 1, 0);
        checkOutput("full_level", fifo_level, 4);
        checkOutput("full_ovf_before", overflow, 0);
`ifdef IOBUS_FULL_WAIT_EN
        begin
            expWrite_t e;
            int n = 0;
            applyStimulus(8'h10, 8'h0C);
            cpu_do = 8'h14;
            wr_n   = 1'b0;
            cpu_ce = 1'b1;
            #1;
            checkOutput("stall_ready", cpu_ready, 0);
            e.dev = 3'd3; e.sub = 2'd0; e.data = 8'h14; e.pushCyc = 0; e.latChk = 0;
            sbQueue.push_back(e);
            @(negedge clk24);
            checkOutput("stall_ready_hold", cpu_ready, 0);
            ch_wready = 8'hFF;
            while (cpu_ready !== 1'b1 && n < 20) begin
                @(negedge clk24);
                n++;
            end
            checkOutput("stall_release", cpu_ready, 1);
            @(negedge clk24);
            cpu_ce = 1'b0;
            wr_n   = 1'b1;
        end
        waitDrain("full_drain");
        checkOutput("full_ovf_after", overflow, 0);
`else
        busWrite(8'h0C, 8'h14, 1, 0, 0);
        checkOutput("drop_ovf", overflow, 1);
        checkOutput("drop_level", fifo_level, 4);
        checkOutput("drop_ready", cpu_ready, 1);
        ch_wready = 8'hFF;
        waitDrain("full_drain");
        checkOutput("full_ovf_sticky", overflow, 1);
`endif
        checkOutput("full_level_after", fifo_level, 0);

        // Head-of-line blocking: channel 0 waits behind stalled channel 3.
        ch_wready = 8'hF7;
        busWrite(8'h0E, 8'hAA, 1, 1, 0);
        busWrite(8'h01, 8'h55, 1, 1, 0);
        repeat (5) @(negedge clk24);
        checkOutput("order_level", fifo_level, 2);
        checkOutput("order_nostb", ch_wstb, 8'h00);
        ch_wready = 8'hFF;
        waitDrain("order_drain");

        // Reset while entries are pending discards them.
        ch_wready = 8'hF7;
        for (int i = 0; i < 3; i++) busWrite(8'h0C, 8'hC0 + 8'(i), 1, 1, 0);
        checkOutput("mid_level", fifo_level, 3);
        @(negedge clk24);
        mreset_n  = 1'b0;
        ch_wready = 8'hFF;
        sbQueue.delete();
        @(negedge clk24);
        checkOutput("mid_rst_level", fifo_level, 0);
        checkOutput("mid_rst_wstb", ch_wstb, 8'h00);
        mreset_n = 1'b1;
        repeat (6) @(negedge clk24);
        checkOutput("post_rst_level", fifo_level, 0);
        checkOutput("post_rst_ovf", overflow, 0);
        checkOutput("final_sb_empty", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
